// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-granular memory responder and its storage.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GNT
    } mem_state_e;

    function automatic int line_size(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Line-wide storage with a registered read-line output; contents survive reset
// and power up holding word i of line a = a*LINE_SIZE + i.
module line_ram
    import mem_pkg::*;
#(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int ADDR_LEN      = 9,
    localparam int LINE_SIZE     = line_size(LINE_ADDR_LEN),
    localparam int LINE_W        = WORD_W * LINE_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                we,
    input  logic                re,
    input  logic [LINE_W-1:0]   wdata,
    output logic [LINE_W-1:0]   rd_line
);

    localparam int DEPTH = 1 << ADDR_LEN;

    function automatic logic [LINE_W-1:0] init_line(input int a);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            l[i*WORD_W +: WORD_W] = WORD_W'(a * LINE_SIZE + i);
        end
        return l;
    endfunction

    logic [LINE_W-1:0] lines [DEPTH];
    logic [LINE_W-1:0] rd_line_q;
    logic [LINE_W-1:0] rd_line_d;

    // Each line carries its power-up pattern; no reset, so contents outlive an aborted transaction.
    for (genvar a = 0; a < DEPTH; a++) begin : g_line
        logic [LINE_W-1:0] line_q = init_line(a);
        logic [LINE_W-1:0] line_d;

        always_comb begin
            line_d = line_q;
            if (we && (addr == ADDR_LEN'(a))) begin
                line_d = wdata;
            end
        end

        always_ff @(posedge clk) begin
            line_q <= line_d;
        end

        assign lines[a] = line_q;
    end

    always_comb begin
        rd_line_d = rd_line_q;
        if (re) begin
            rd_line_d = lines[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_line_q <= '0;
        end else begin
            rd_line_q <= rd_line_d;
        end
    end

    assign rd_line = rd_line_q;

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder for line refill/writeback: one request at a time,
// fixed latency, single-cycle gnt pulse, read line held until the next read.
module line_mem_responder
    import mem_pkg::*;
#(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int ADDR_LEN      = 9,
    parameter  int RD_LATENCY    = 8,
    parameter  int WR_LATENCY    = 8,
    localparam int LINE_W        = WORD_W * line_size(LINE_ADDR_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                gnt,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                rd_req,
    output logic [LINE_W-1:0]   rd_line,
    input  logic                wr_req,
    input  logic [LINE_W-1:0]   wr_line,
    output logic                busy
);

    localparam logic [7:0] RD_CNT = 8'(RD_LATENCY - 1);
    localparam logic [7:0] WR_CNT = 8'(WR_LATENCY - 1);

    mem_state_e          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                is_wr_q, is_wr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                mem_we;
    logic                mem_re;

    // Write wins when both requests are up, so a writeback lands before the refill.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_d = BUSY;
                    addr_d  = addr;
                    is_wr_d = wr_req;
                    wdata_d = wr_line;
                    cnt_d   = wr_req ? WR_CNT : RD_CNT;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = GNT;
                    mem_we  = is_wr_q;
                    mem_re  = !is_wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GNT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt  = (state_q == GNT);
    assign busy = (state_q == BUSY);

    line_ram #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .ADDR_LEN     (ADDR_LEN)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr_q),
        .we     (mem_we),
        .re     (mem_re),
        .wdata  (wdata_q),
        .rd_line(rd_line)
    );

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench: stimulus queues expected completions, per-instance monitors
// check gnt timing, busy length and rd_line contents/stability.
module tb_line_mem_responder;

    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] line_t;

    typedef struct {
        bit    is_rd;
        line_t data;
        int    gnt_cyc;
        int    busy_len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [8:0] a_addr = '0;
    logic       a_rd_req = 1'b0;
    logic       a_wr_req = 1'b0;
    line_t      a_wr_line = '0;
    logic       a_gnt;
    logic       a_busy;
    line_t      a_rd_line;

    logic [8:0] b_addr = '0;
    logic       b_rd_req = 1'b0;
    logic       b_wr_req = 1'b0;
    line_t      b_wr_line = '0;
    logic       b_gnt;
    logic       b_busy;
    line_t      b_rd_line;

    int    cyc = 0;
    int    pass_cnt = 0;
    int    total_cnt = 0;
    exp_t  exp_a[$];
    exp_t  exp_b[$];
    exp_t  ea;
    exp_t  eb;
    line_t model_a = '0;
    line_t model_b = '0;
    int    busy_run_a = 0;
    int    busy_run_b = 0;

    line_mem_responder #(
        .LINE_ADDR_LEN(3), .ADDR_LEN(9), .RD_LATENCY(4), .WR_LATENCY(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .gnt(a_gnt), .addr(a_addr), .rd_req(a_rd_req),
        .rd_line(a_rd_line), .wr_req(a_wr_req), .wr_line(a_wr_line), .busy(a_busy)
    );

    line_mem_responder #(
        .LINE_ADDR_LEN(3), .ADDR_LEN(9), .RD_LATENCY(1), .WR_LATENCY(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .gnt(b_gnt), .addr(b_addr), .rd_req(b_rd_req),
        .rd_line(b_rd_line), .wr_req(b_wr_req), .wr_line(b_wr_line), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic line_t pattern(input int a);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'(a * 8 + i);
        return l;
    endfunction

    function automatic line_t fill(input logic [31:0] base, input bit inc);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = inc ? base + 32'(i) : base;
        return l;
    endfunction

    task automatic checkOutput(input string name, input line_t actual, input line_t expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, wanted %h", name, cyc, actual, expected);
        end
    endtask

    task automatic waitGntA();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_gnt && n < 40);
        if (!a_gnt) begin
            total_cnt++;
            $display("[TB] FAIL gnt_timeout_a: no gnt within %0d cycles", n);
        end
    endtask

    task automatic waitGntB();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_gnt && n < 40);
        if (!b_gnt) begin
            total_cnt++;
            $display("[TB] FAIL gnt_timeout_b: no gnt within %0d cycles", n);
        end
    endtask

    // Issue one transaction on instance A (latency 4) from an idle negedge and wait it out.
    task automatic applyStimulus(input bit is_wr, input logic [8:0] line_addr, input line_t wdata,
                                 input line_t exp_rd, input bit disturb);
        exp_t e;
        a_addr    = line_addr;
        a_wr_line = wdata;
        a_wr_req  = is_wr;
        a_rd_req  = !is_wr;
        e.is_rd    = !is_wr;
        e.data     = exp_rd;
        e.gnt_cyc  = cyc + 1 + 4;
        e.busy_len = 4;
        exp_a.push_back(e);
        if (disturb) begin
            @(negedge clk);
            a_addr    = 9'd9;
            a_wr_line = '1;
        end
        waitGntA();
        a_wr_req = 1'b0;
        a_rd_req = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_gnt_a", line_t'(a_gnt), '0);
            checkOutput("reset_busy_a", line_t'(a_busy), '0);
            checkOutput("reset_rd_line_a", a_rd_line, '0);
            model_a = '0;
            busy_run_a = 0;
            exp_a.delete();
        end else if (a_gnt) begin
            if (exp_a.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_gnt_a: gnt at cycle %0d, nothing pending", cyc);
            end else begin
                ea = exp_a.pop_front();
                checkOutput("gnt_cycle_a", line_t'(cyc), line_t'(ea.gnt_cyc));
                checkOutput("busy_len_a", line_t'(busy_run_a), line_t'(ea.busy_len));
                if (ea.is_rd) model_a = ea.data;
                checkOutput("rd_line_a", a_rd_line, model_a);
            end
            busy_run_a = 0;
        end else begin
            if (a_busy) busy_run_a++;
            checkOutput("rd_line_hold_a", a_rd_line, model_a);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_gnt_b", line_t'(b_gnt), '0);
            checkOutput("reset_rd_line_b", b_rd_line, '0);
            model_b = '0;
            busy_run_b = 0;
            exp_b.delete();
        end else if (b_gnt) begin
            if (exp_b.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_gnt_b: gnt at cycle %0d, nothing pending", cyc);
            end else begin
                eb = exp_b.pop_front();
                checkOutput("gnt_cycle_b", line_t'(cyc), line_t'(eb.gnt_cyc));
                checkOutput("busy_len_b", line_t'(busy_run_b), line_t'(eb.busy_len));
                if (eb.is_rd) model_b = eb.data;
                checkOutput("rd_line_b", b_rd_line, model_b);
            end
            busy_run_b = 0;
        end else begin
            if (b_busy) busy_run_b++;
            checkOutput("rd_line_hold_b", b_rd_line, model_b);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] read line 5");
        applyStimulus(1'b0, 9'd5, '0, pattern(5), 1'b0);

        $display("[TB] write line 5 then read it back");
        applyStimulus(1'b1, 9'd5, fill(32'hA0, 1'b1), '0, 1'b0);
        applyStimulus(1'b0, 9'd5, '0, fill(32'hA0, 1'b1), 1'b0);

        $display("[TB] simultaneous write and read of line 3");
        a_addr    = 9'd3;
        a_wr_line = fill(32'h55, 1'b0);
        a_wr_req  = 1'b1;
        a_rd_req  = 1'b1;
        e.is_rd = 1'b0; e.data = '0; e.gnt_cyc = cyc + 5; e.busy_len = 4;
        exp_a.push_back(e);
        e.is_rd = 1'b1; e.data = fill(32'h55, 1'b0); e.gnt_cyc = cyc + 11; e.busy_len = 4;
        exp_a.push_back(e);
        waitGntA();
        a_wr_req = 1'b0;
        waitGntA();
        a_rd_req = 1'b0;
        @(negedge clk);

        $display("[TB] read line 2 with addr disturbed while busy");
        applyStimulus(1'b0, 9'd2, '0, pattern(2), 1'b1);

        $display("[TB] reset during write to line 7");
        a_addr    = 9'd7;
        a_wr_line = fill(32'hDEAD0000, 1'b1);
        a_wr_req  = 1'b1;
        e.is_rd = 1'b0; e.data = '0; e.gnt_cyc = cyc + 5; e.busy_len = 4;
        exp_a.push_back(e);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        a_wr_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 9'd7, '0, pattern(7), 1'b0);

        $display("[TB] back-to-back reads of lines 0..2 at latency 1");
        b_addr   = 9'd0;
        b_rd_req = 1'b1;
        e.is_rd = 1'b1; e.data = pattern(0); e.gnt_cyc = cyc + 2; e.busy_len = 1;
        exp_b.push_back(e);
        for (int i = 0; i < 3; i++) begin
            waitGntB();
            if (i < 2) begin
                b_addr = 9'(i + 1);
                e.is_rd = 1'b1; e.data = pattern(i + 1); e.gnt_cyc = cyc + 3; e.busy_len = 1;
                exp_b.push_back(e);
            end
        end
        b_rd_req = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("pending_a", line_t'(exp_a.size()), '0);
        checkOutput("pending_b", line_t'(exp_b.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
